// File: rtl/mmio_timer_responder_pkg.sv
// -----------------------------------------------------------------------------
// mmio_timer_responder_pkg
//   Shared constants for the memory-mapped timer/LED/display responder:
//   register byte offsets, their word indices within the window, TCON bit
//   positions and the default window base address.
// -----------------------------------------------------------------------------
package mmio_timer_responder_pkg;

    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h4000_0000;

    // Byte offsets of the six registers inside the window
    localparam logic [4:0] TH_OFF      = 5'h00;
    localparam logic [4:0] TL_OFF      = 5'h04;
    localparam logic [4:0] TCON_OFF    = 5'h08;
    localparam logic [4:0] LED_OFF     = 5'h0C;
    localparam logic [4:0] DIGITS_OFF  = 5'h10;
    localparam logic [4:0] SYSTICK_OFF = 5'h14;

    // Word indices (Address[4:2]) derived from the offsets
    localparam logic [2:0] TH_W      = TH_OFF[4:2];
    localparam logic [2:0] TL_W      = TL_OFF[4:2];
    localparam logic [2:0] TCON_W    = TCON_OFF[4:2];
    localparam logic [2:0] LED_W     = LED_OFF[4:2];
    localparam logic [2:0] DIGITS_W  = DIGITS_OFF[4:2];
    localparam logic [2:0] SYSTICK_W = SYSTICK_OFF[4:2];

    // Highest decoded word; words 6 and 7 of the 32-byte block do not hit
    localparam logic [2:0] LAST_W = SYSTICK_W;

    // TCON bit positions
    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_ST = 2;

endpackage

// File: rtl/mmio_timer_responder_timer_core.sv
// -----------------------------------------------------------------------------
// timer_core
//   Reloadable up-counting timer with prescaler and sticky overflow status.
//   Ports:
//     clk      in   system clock
//     reset    in   synchronous active-low reset
//     th_we    in   write strobe for TH (reload value)
//     tl_we    in   write strobe for TL (counter)
//     tcon_we  in   write strobe for TCON (enable, irq-enable, status W1C)
//     wdata    in   store data shared by all three strobes
//     th       out  current TH
//     tl       out  current TL
//     tcon     out  current TCON[2:0]
//     irq      out  registered status & irq-enable
// -----------------------------------------------------------------------------
module timer_core
    import mmio_timer_responder_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        th_we,
    input  logic        tl_we,
    input  logic        tcon_we,
    input  logic [31:0] wdata,
    output logic [31:0] th,
    output logic [31:0] tl,
    output logic [2:0]  tcon,
    output logic        irq
);

    localparam logic [31:0] PRESC_LAST = PRESCALE - 32'd1;

    logic [31:0] presc_r;
    logic [31:0] th_r;
    logic [31:0] tl_r;
    logic [2:0]  tcon_r;
    logic        irq_r;

    logic        tick_s;
    logic        ovf_s;
    logic        set_st_s;
    logic [31:0] presc_nxt_s;
    logic [31:0] th_nxt_s;
    logic [31:0] tl_nxt_s;
    logic [2:0]  tcon_nxt_s;
    logic        irq_nxt_s;

    // Next-state: prescaler, reload/count, status set versus W1C.
    // tick and overflow come from the pre-write state, so a store that
    // disables the timer on a tick edge still lets that tick land, and a
    // reload on the same edge as a TH store uses the old TH.
    always_comb begin
        tick_s   = tcon_r[TCON_EN] && (presc_r == PRESC_LAST);
        ovf_s    = tick_s && (tl_r == 32'hFFFF_FFFF);
        set_st_s = ovf_s && tcon_r[TCON_IE];

        // Prescaler holds (not cleared) while disabled
        if (tick_s) begin
            presc_nxt_s = 32'd0;
        end else if (tcon_r[TCON_EN]) begin
            presc_nxt_s = presc_r + 32'd1;
        end else begin
            presc_nxt_s = presc_r;
        end

        if (th_we) begin
            th_nxt_s = wdata;
        end else begin
            th_nxt_s = th_r;
        end

        // CPU store to TL beats a tick on the same edge
        if (tl_we) begin
            tl_nxt_s = wdata;
        end else if (ovf_s) begin
            tl_nxt_s = th_r;
        end else if (tick_s) begin
            tl_nxt_s = tl_r + 32'd1;
        end else begin
            tl_nxt_s = tl_r;
        end

        if (tcon_we) begin
            tcon_nxt_s[TCON_EN] = wdata[TCON_EN];
            tcon_nxt_s[TCON_IE] = wdata[TCON_IE];
        end else begin
            tcon_nxt_s[TCON_EN] = tcon_r[TCON_EN];
            tcon_nxt_s[TCON_IE] = tcon_r[TCON_IE];
        end

        // Overflow setting the status beats a W1C on the same edge
        if (set_st_s) begin
            tcon_nxt_s[TCON_ST] = 1'b1;
        end else if (tcon_we && wdata[TCON_ST]) begin
            tcon_nxt_s[TCON_ST] = 1'b0;
        end else begin
            tcon_nxt_s[TCON_ST] = tcon_r[TCON_ST];
        end

        // irq is registered from the next TCON so it rises on the status edge
        irq_nxt_s = tcon_nxt_s[TCON_ST] & tcon_nxt_s[TCON_IE];
    end

    // Timer state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            presc_r <= 32'd0;
            th_r    <= 32'd0;
            tl_r    <= 32'd0;
            tcon_r  <= 3'd0;
            irq_r   <= 1'b0;
        end else begin
            presc_r <= presc_nxt_s;
            th_r    <= th_nxt_s;
            tl_r    <= tl_nxt_s;
            tcon_r  <= tcon_nxt_s;
            irq_r   <= irq_nxt_s;
        end
    end

    assign th   = th_r;
    assign tl   = tl_r;
    assign tcon = tcon_r;
    assign irq  = irq_r;

endmodule

// File: rtl/mmio_timer_responder.sv
// -----------------------------------------------------------------------------
// mmio_timer_responder
//   Peripheral responder on the CPU data-memory bus. Decodes a 6-word window
//   at BASE_ADDR and serves TH, TL, TCON, LED, DIGITS and a free-running
//   SYSTICK. The surrounding top level selects ReadData when hit is high.
//   Ports:
//     clk        in   system clock
//     reset      in   synchronous active-low reset
//     Address    in   byte address from the MEM stage
//     WriteData  in   store data
//     MemRead    in   load strobe (one cycle per access)
//     MemWrite   in   store strobe (one cycle per access)
//     ReadData   out  combinational load data, 0 unless MemRead && hit
//     hit        out  combinational window decode
//     irq        out  timer interrupt (TCON status & irq-enable)
//     led        out  LED register
//     digits     out  display register {AN[3:0], BCD[7:0]}
// -----------------------------------------------------------------------------
module mmio_timer_responder
    import mmio_timer_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT,
    parameter int unsigned PRESCALE  = 1
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] ReadData,
    output logic        hit,
    output logic        irq,
    output logic [15:0] led,
    output logic [11:0] digits
);

    logic [2:0]  word_s;
    logic        hit_s;
    logic        th_we_s;
    logic        tl_we_s;
    logic        tcon_we_s;
    logic        led_we_s;
    logic        digits_we_s;
    logic [31:0] rd_mux_s;
    logic [31:0] read_data_s;
    logic [31:0] th_s;
    logic [31:0] tl_s;
    logic [2:0]  tcon_s;
    logic        irq_s;
    logic        unused_addr_s;

    logic [15:0] led_r;
    logic [11:0] digits_r;
    logic [31:0] systick_r;

    // Word accesses only; byte lane bits are intentionally ignored
    assign unused_addr_s = ^Address[1:0];
    assign word_s        = Address[4:2];

    // Window decode: 32-byte block match and only the first six words
    always_comb begin
        if ((Address[31:5] == BASE_ADDR[31:5]) && (word_s <= LAST_W)) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
    end

    // Write strobes; SYSTICK is read-only so its word has no strobe
    always_comb begin
        th_we_s     = 1'b0;
        tl_we_s     = 1'b0;
        tcon_we_s   = 1'b0;
        led_we_s    = 1'b0;
        digits_we_s = 1'b0;
        if (MemWrite && hit_s) begin
            case (word_s)
                TH_W:     th_we_s     = 1'b1;
                TL_W:     tl_we_s     = 1'b1;
                TCON_W:   tcon_we_s   = 1'b1;
                LED_W:    led_we_s    = 1'b1;
                DIGITS_W: digits_we_s = 1'b1;
                default:  th_we_s     = 1'b0;
            endcase
        end else begin
            th_we_s = 1'b0;
        end
    end

    // Read mux from current (pre-write) state, gated by a hitting load
    always_comb begin
        case (word_s)
            TH_W:      rd_mux_s = th_s;
            TL_W:      rd_mux_s = tl_s;
            TCON_W:    rd_mux_s = {29'd0, tcon_s};
            LED_W:     rd_mux_s = {16'd0, led_r};
            DIGITS_W:  rd_mux_s = {20'd0, digits_r};
            SYSTICK_W: rd_mux_s = systick_r;
            default:   rd_mux_s = 32'h0;
        endcase
        if (MemRead && hit_s) begin
            read_data_s = rd_mux_s;
        end else begin
            read_data_s = 32'h0;
        end
    end

    // LED, DIGITS and the free-running SYSTICK
    always_ff @(posedge clk) begin
        if (!reset) begin
            led_r     <= 16'h0;
            digits_r  <= 12'h0;
            systick_r <= 32'h0;
        end else begin
            if (led_we_s) begin
                led_r <= WriteData[15:0];
            end
            if (digits_we_s) begin
                digits_r <= WriteData[11:0];
            end
            systick_r <= systick_r + 32'd1;
        end
    end

    timer_core #(
        .PRESCALE (PRESCALE)
    ) u_timer_core (
        .clk     (clk),
        .reset   (reset),
        .th_we   (th_we_s),
        .tl_we   (tl_we_s),
        .tcon_we (tcon_we_s),
        .wdata   (WriteData),
        .th      (th_s),
        .tl      (tl_s),
        .tcon    (tcon_s),
        .irq     (irq_s)
    );

    assign ReadData = read_data_s;
    assign hit      = hit_s;
    assign irq      = irq_s;
    assign led      = led_r;
    assign digits   = digits_r;

endmodule

// File: tb/tb_mmio_timer_responder.sv
// -----------------------------------------------------------------------------
// tb_mmio_timer_responder
//   Two responders (PRESCALE 1 and 4) share one bus. A behavioural model
//   holds the six registers as an array indexed by word offset and advances
//   them from the register-map rules; directed scenarios add fixed expected
//   values, then a randomized phase runs against the model.
// -----------------------------------------------------------------------------
module tb_mmio_timer_responder;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemRead;
    logic        MemWrite;

    logic [31:0] rdata_0, rdata_1;
    logic        hit_0, hit_1, irq_0, irq_1;
    logic [15:0] led_0, led_1;
    logic [11:0] digits_0, digits_1;

    int checks   = 0;
    int failures = 0;

    // Model: regs[inst][word] with word 0..5 = TH, TL, TCON, LED, DIGITS, SYSTICK
    logic [31:0] m_regs [2][6];
    logic [31:0] m_presc [2];

    // Values captured at the sampling point of the last bus cycle
    logic [31:0] rd0_q, rd1_q;
    logic        hit0_q;

    always #5 clk = ~clk;

    mmio_timer_responder #(.BASE_ADDR(BASE), .PRESCALE(1)) u_dut0 (
        .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .ReadData(rdata_0), .hit(hit_0),
        .irq(irq_0), .led(led_0), .digits(digits_0)
    );

    mmio_timer_responder #(.BASE_ADDR(BASE), .PRESCALE(4)) u_dut1 (
        .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .ReadData(rdata_1), .hit(hit_1),
        .irq(irq_1), .led(led_1), .digits(digits_1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int unsigned prescale_of(input int inst);
        return (inst == 0) ? 1 : 4;
    endfunction

    function automatic logic m_hit(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'd24);
    endfunction

    function automatic logic [31:0] m_read(input int inst, input logic [31:0] a);
        if (m_hit(a)) return m_regs[inst][int'((a - BASE) >> 2)];
        return 32'h0;
    endfunction

    // Advance one model instance across a clock edge
    task automatic model_edge(input int inst, input logic rst_v, input logic wr,
                              input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] th, tl, tc, p;
        logic        tick, ovf, set_st;
        int          w;
        if (!rst_v) begin
            for (int k = 0; k < 6; k++) m_regs[inst][k] = 32'h0;
            m_presc[inst] = 32'h0;
            return;
        end
        th = m_regs[inst][0];
        tl = m_regs[inst][1];
        tc = m_regs[inst][2];
        p  = m_presc[inst];
        tick   = tc[0] && (p == prescale_of(inst) - 1);
        ovf    = tick && (tl == 32'hFFFF_FFFF);
        set_st = ovf && tc[1];
        if (tc[0]) m_presc[inst] = tick ? 32'h0 : p + 32'd1;
        if (tick) m_regs[inst][1] = ovf ? th : tl + 32'd1;
        if (set_st) m_regs[inst][2][2] = 1'b1;
        if (wr && m_hit(a)) begin
            w = int'((a - BASE) >> 2);
            case (w)
                0: m_regs[inst][0] = wd;
                1: m_regs[inst][1] = wd;
                2: begin
                    m_regs[inst][2][1:0] = wd[1:0];
                    if (wd[2] && !set_st) m_regs[inst][2][2] = 1'b0;
                end
                3: m_regs[inst][3] = {16'h0, wd[15:0]};
                4: m_regs[inst][4] = {20'h0, wd[11:0]};
                default: ;
            endcase
        end
        m_regs[inst][5] = m_regs[inst][5] + 32'd1;
    endtask

    // One bus cycle: combinational outputs at negedge, registered ones after posedge
    task automatic bus_cycle(input logic rst_v, input logic rd, input logic wr,
                             input logic [31:0] a, input logic [31:0] wd);
        reset = rst_v; MemRead = rd; MemWrite = wr; Address = a; WriteData = wd;
        @(negedge clk);
        check_eq("d0_hit", {31'd0, hit_0}, {31'd0, m_hit(a)});
        check_eq("d1_hit", {31'd0, hit_1}, {31'd0, m_hit(a)});
        check_eq("d0_rdata", rdata_0, rd ? m_read(0, a) : 32'h0);
        check_eq("d1_rdata", rdata_1, rd ? m_read(1, a) : 32'h0);
        rd0_q = rdata_0; rd1_q = rdata_1; hit0_q = hit_0;
        @(posedge clk);
        model_edge(0, rst_v, wr, a, wd);
        model_edge(1, rst_v, wr, a, wd);
        #1;
        for (int i = 0; i < 2; i++) begin
            check_eq(i == 0 ? "d0_irq" : "d1_irq", {31'd0, (i == 0) ? irq_0 : irq_1},
                     {31'd0, m_regs[i][2][2] & m_regs[i][2][1]});
            check_eq(i == 0 ? "d0_led" : "d1_led", {16'd0, (i == 0) ? led_0 : led_1}, m_regs[i][3]);
            check_eq(i == 0 ? "d0_digits" : "d1_digits", {20'd0, (i == 0) ? digits_0 : digits_1},
                     m_regs[i][4]);
        end
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic wr_reg(input logic [4:0] off, input logic [31:0] d);
        bus_cycle(1'b1, 1'b0, 1'b1, BASE + {27'd0, off}, d);
    endtask

    task automatic rd_reg(input logic [4:0] off);
        bus_cycle(1'b1, 1'b1, 1'b0, BASE + {27'd0, off}, 32'h0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) bus_cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) bus_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] st0;
        logic [31:0] a, wd;
        logic        rd, wr, rv;
        int          w;

        reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        Address = 32'h0; WriteData = 32'h0;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 6; k++) m_regs[i][k] = 32'h0;
            m_presc[i] = 32'h0;
        end

        // Reset: everything reads back zero
        do_reset(2);
        rd_reg(5'h14);
        check_eq("rst_systick", rd0_q, 32'h0);
        for (int k = 0; k < 5; k++) begin
            rd_reg(5'(k * 4));
            check_eq("rst_reg0", rd0_q, 32'h0);
            check_eq("rst_reg1", rd1_q, 32'h0);
        end
        check_eq("rst_irq", {31'd0, irq_0}, 32'h0);

        // Reload and irq with PRESCALE 1
        do_reset(1);
        wr_reg(5'h00, 32'hFFFF_FFFC);
        wr_reg(5'h04, 32'hFFFF_FFFE);
        wr_reg(5'h08, 32'h0000_0003);
        rd_reg(5'h04);
        check_eq("rl_tl_fe", rd0_q, 32'hFFFF_FFFE);
        rd_reg(5'h04);
        check_eq("rl_tl_ff", rd0_q, 32'hFFFF_FFFF);
        check_eq("rl_irq_set", {31'd0, irq_0}, 32'h1);
        rd_reg(5'h04);
        check_eq("rl_tl_reload", rd0_q, 32'hFFFF_FFFC);
        rd_reg(5'h08);
        check_eq("rl_tcon7", rd0_q, 32'h7);
        wr_reg(5'h08, 32'h0000_0007);
        check_eq("rl_irq_clr", {31'd0, irq_0}, 32'h0);
        rd_reg(5'h08);
        check_eq("rl_tcon3", rd0_q, 32'h3);

        // W1C on the overflow edge: status stays set
        do_reset(1);
        wr_reg(5'h00, 32'h0000_0010);
        wr_reg(5'h04, 32'hFFFF_FFFE);
        wr_reg(5'h08, 32'h0000_0003);
        idle(1);
        wr_reg(5'h08, 32'h0000_0007);
        check_eq("w1c_irq", {31'd0, irq_0}, 32'h1);
        rd_reg(5'h08);
        check_eq("w1c_tcon", rd0_q, 32'h7);

        // Prescale 4 on the second instance
        do_reset(1);
        wr_reg(5'h04, 32'h0);
        wr_reg(5'h08, 32'h1);
        idle(12);
        wr_reg(5'h08, 32'h0);
        rd_reg(5'h04);
        check_eq("ps_tl3", rd1_q, 32'h3);
        idle(10);
        rd_reg(5'h04);
        check_eq("ps_frozen", rd1_q, 32'h3);

        // Decode
        wr_reg(5'h0C, 32'h0000_1234);
        check_eq("dec_led", {16'd0, led_0}, 32'h1234);
        rd_reg(5'h14);
        st0 = rd0_q;
        wr_reg(5'h14, 32'h0);
        rd_reg(5'h14);
        check_eq("dec_systick_ro", rd0_q, st0 + 32'd2);
        bus_cycle(1'b1, 1'b1, 1'b0, BASE + 32'h18, 32'h0);
        check_eq("dec_hit18", {31'd0, hit0_q}, 32'h0);
        check_eq("dec_rd18", rd0_q, 32'h0);
        bus_cycle(1'b1, 1'b0, 1'b1, 32'h1000_0000, 32'hFFFF_FFFF);
        check_eq("dec_nohit_led", {16'd0, led_0}, 32'h1234);

        // Store to TL on a tick edge
        do_reset(1);
        wr_reg(5'h08, 32'h1);
        wr_reg(5'h04, 32'h5);
        rd_reg(5'h04);
        check_eq("col_tl5", rd0_q, 32'h5);
        rd_reg(5'h04);
        check_eq("col_tl6", rd0_q, 32'h6);

        // Randomized traffic against the model
        do_reset(1);
        for (int n = 0; n < 600; n++) begin
            w  = $urandom_range(0, 7);
            a  = ($urandom_range(0, 9) != 0) ? BASE + 32'(w * 4) + 32'($urandom_range(0, 3))
                                             : $urandom;
            rd = ($urandom_range(0, 1) == 1);
            wr = ($urandom_range(0, 2) == 0);
            rv = ($urandom_range(0, 49) != 0);
            wd = $urandom;
            if (w == 1 && $urandom_range(0, 1) == 1) wd = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            if (w == 2 && $urandom_range(0, 3) != 0) wd[0] = 1'b1;
            bus_cycle(rv, rd, wr, a, wd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
